// File: rtl/dm_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dm_store_buffer
// Brief    : In-order store queue ahead of the data memory. It shares the
//            single DM port with loads and drains one entry per cycle.
// Revision : 1.0
// ============================================================================
module dm_store_buffer #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_align,
    input  logic [31:0] st_pc,
    output logic        st_ready,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [1:0]  ld_align,
    input  logic        ld_sign,
    output logic        ld_stall,
    output logic        align_err,
    output logic        empty,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    output logic [1:0]  dm_align,
    output logic        dm_sign,
    output logic [31:0] dm_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] c_depth        = CW'(DEPTH);
    localparam logic [SW-1:0] c_starve_limit = SW'(STARVE_LIMIT);

    logic [31:0]   r_addr  [DEPTH];
    logic [31:0]   r_data  [DEPTH];
    logic [1:0]    r_align [DEPTH];
    logic [31:0]   r_pc    [DEPTH];

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;
    logic          r_align_err;

    logic          w_aligned;
    logic          w_enq;
    logic          w_hit;
    logic          w_force;
    logic          w_drain;
    logic [DEPTH-1:0] w_hit_vec;

    always_comb begin
        w_aligned = 1'b0;
        case (st_align)
            2'b00:   w_aligned = (st_addr[1:0] == 2'b00);
            2'b01:   w_aligned = ~st_addr[0];
            2'b10:   w_aligned = 1'b1;
            default: w_aligned = 1'b0;
        endcase
    end

    assign st_ready = (r_count != c_depth);
    assign empty    = (r_count == '0);
    assign w_enq    = st_valid & st_ready & w_aligned;

    // An entry is live when its distance from the head is below the count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
        logic [PW-1:0] w_off;
        assign w_off        = PW'(i) - r_head;
        assign w_hit_vec[i] = (CW'(w_off) < r_count) &&
                              (r_addr[i][13:2] == ld_addr[13:2]);
    end

    assign w_hit    = ld_valid & (|w_hit_vec);
    assign w_force  = (r_starve == c_starve_limit) & (r_count != '0);
    assign ld_stall = w_hit | w_force;
    assign w_drain  = (r_count != '0) & (~ld_valid | ld_stall);

    assign dm_we    = w_drain;
    assign dm_addr  = w_drain ? r_addr[r_head]  : ld_addr;
    assign dm_wd    = w_drain ? r_data[r_head]  : 32'h0;
    assign dm_align = w_drain ? r_align[r_head] : ld_align;
    assign dm_sign  = w_drain ? 1'b0            : ld_sign;
    assign dm_pc    = w_drain ? r_pc[r_head]    : 32'h0;
    assign align_err = r_align_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_starve    <= '0;
            r_align_err <= 1'b0;
        end else begin
            r_align_err <= st_valid & st_ready & ~w_aligned;
            if (w_enq) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_drain) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drain || (r_count == '0)) begin
                r_starve <= '0;
            end else if (ld_valid && !ld_stall && (r_starve != c_starve_limit)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    // Entry payload is only meaningful while occupied, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail]  <= st_addr;
            r_data[r_tail]  <= st_data;
            r_align[r_tail] <= st_align;
            r_pc[r_tail]    <= st_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_store_buffer
// Brief    : Directed stimulus with a scoreboard of expected DM writes and
//            align-error pulses, checked by an independent monitor.
// Revision : 1.0
// ============================================================================
module tb_dm_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [1:0]  st_align = '0;
    logic [31:0] st_pc = '0;
    logic        st_ready;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [1:0]  ld_align = '0;
    logic        ld_sign = 1'b0;
    logic        ld_stall;
    logic        align_err;
    logic        empty;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [1:0]  dm_align;
    logic        dm_sign;
    logic [31:0] dm_pc;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  al;
        logic [31:0] pc;
    } wr_t;

    wr_t exp_q[$];
    bit  aerr_q[$];
    wr_t e;
    int  errors = 0;
    int  checks = 0;

    dm_store_buffer #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .st_align(st_align), .st_pc(st_pc), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_align(ld_align),
        .ld_sign(ld_sign), .ld_stall(ld_stall), .align_err(align_err),
        .empty(empty), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd),
        .dm_align(dm_align), .dm_sign(dm_sign), .dm_pc(dm_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] al, input logic [31:0] pc, input bit expect_write);
        wr_t w;
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_align = al;
        st_pc    = pc;
        if (expect_write) begin
            w.addr = a; w.wd = d; w.al = al; w.pc = pc;
            exp_q.push_back(w);
        end
    endtask

    // Monitor: every DM write and every align_err pulse must match a queued expectation.
    always @(negedge clk) begin
        if (dm_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h wd=%h pc=%h", dm_addr, dm_wd, dm_pc);
            end else begin
                e = exp_q.pop_front();
                if (dm_addr !== e.addr || dm_wd !== e.wd || dm_align !== e.al ||
                    dm_pc !== e.pc || dm_sign !== 1'b0) begin
                    errors++;
                    $display("FAIL dm_write got addr=%h wd=%h al=%b pc=%h sign=%b exp addr=%h wd=%h al=%b pc=%h sign=0",
                             dm_addr, dm_wd, dm_align, dm_pc, dm_sign, e.addr, e.wd, e.al, e.pc);
                end
            end
        end
        if (align_err === 1'b1) begin
            checks++;
            if (aerr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_align_err got=1 exp=0");
            end else begin
                void'(aerr_q.pop_front());
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_st_ready", {31'b0, st_ready}, 32'd1);
        chk("rst_dm_we", {31'b0, dm_we}, 32'd0);
        chk("rst_align_err", {31'b0, align_err}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Single store, no loads
        tick(); st(32'h10, 32'h12345678, 2'b00, 32'h3000, 1'b1);
        tick(); st_valid = 1'b0;
        #2; chk("single_we", {31'b0, dm_we}, 32'd1);
        tick(); #2;
        chk("single_empty", {31'b0, empty}, 32'd1);
        chk("single_we_after", {31'b0, dm_we}, 32'd0);

        // Fill the buffer while unrelated loads hold the port
        ld_valid = 1'b1; ld_addr = 32'h1000; ld_align = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick(); st(32'(i * 4), 32'hA0 + 32'(i), 2'b00, 32'h100 + 32'(i * 4), 1'b1);
        end
        tick(); st(32'h10, 32'hEE, 2'b00, 32'h200, 1'b0);
        #2;
        chk("full_st_ready", {31'b0, st_ready}, 32'd0);
        chk("full_we_blocked", {31'b0, dm_we}, 32'd0);
        chk("full_no_stall", {31'b0, ld_stall}, 32'd0);
        tick(); st_valid = 1'b0; ld_valid = 1'b0;
        for (int i = 0; i < 8 && !empty; i++) tick();
        #2; chk("full_drained", {31'b0, empty}, 32'd1);
        chk("full_queue_done", 32'(exp_q.size()), 32'd0);

        // Load hazard against a queued byte store
        tick(); st(32'h21, 32'hAB, 2'b10, 32'h4000, 1'b1);
        tick(); st_valid = 1'b0;
        ld_valid = 1'b1; ld_addr = 32'h20; ld_align = 2'b00; ld_sign = 1'b1;
        #2;
        chk("hazard_stall", {31'b0, ld_stall}, 32'd1);
        chk("hazard_we", {31'b0, dm_we}, 32'd1);
        tick(); #2;
        chk("hazard_release", {31'b0, ld_stall}, 32'd0);
        chk("hazard_ld_addr", dm_addr, 32'h20);
        chk("hazard_ld_we", {31'b0, dm_we}, 32'd0);
        chk("hazard_ld_sign", {31'b0, dm_sign}, 32'd1);
        chk("hazard_ld_wd", dm_wd, 32'h0);
        chk("hazard_ld_pc", dm_pc, 32'h0);
        ld_sign = 1'b0;

        // Starvation: one pending store under a continuous unrelated load stream
        ld_addr = 32'h2000;
        tick(); st(32'h40, 32'hCAFEF00D, 2'b00, 32'h5000, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick(); st_valid = 1'b0;
            #2; chk("starve_blocked", {30'b0, ld_stall, dm_we}, 32'd0);
        end
        tick(); #2;
        chk("starve_force_stall", {31'b0, ld_stall}, 32'd1);
        chk("starve_force_we", {31'b0, dm_we}, 32'd1);
        tick(); #2;
        chk("starve_after_stall", {31'b0, ld_stall}, 32'd0);
        chk("starve_after_we", {31'b0, dm_we}, 32'd0);
        chk("starve_ld_addr", dm_addr, 32'h2000);
        ld_valid = 1'b0;

        // Misaligned and reserved stores are dropped with a one-cycle error
        tick(); st(32'h3, 32'h1111, 2'b01, 32'h6000, 1'b0); aerr_q.push_back(1'b1);
        tick(); st(32'h6, 32'h2222, 2'b00, 32'h6004, 1'b0); aerr_q.push_back(1'b1);
        tick(); st_valid = 1'b0;
        #2; chk("misalign_empty", {31'b0, empty}, 32'd1);
        tick(); #2; chk("misalign_pulse_end", {31'b0, align_err}, 32'd0);
        st(32'h0, 32'h3333, 2'b11, 32'h6008, 1'b0); aerr_q.push_back(1'b1);
        tick(); st(32'h3, 32'h5A, 2'b10, 32'h600C, 1'b1);
        tick(); st_valid = 1'b0;
        #2; chk("byte_no_err", {31'b0, align_err}, 32'd0);
        tick();

        // Reset asserted between edges with three stores queued
        ld_valid = 1'b1; ld_addr = 32'h3000;
        tick(); st(32'h100, 32'h1, 2'b00, 32'h7000, 1'b0);
        tick(); st(32'h104, 32'h2, 2'b00, 32'h7004, 1'b0);
        tick(); st(32'h108, 32'h3, 2'b00, 32'h7008, 1'b0);
        tick(); st_valid = 1'b0;
        #1; chk("pre_rst_not_empty", {31'b0, empty}, 32'd0);
        #1; rst_n = 1'b0;
        #1;
        chk("async_rst_we", {31'b0, dm_we}, 32'd0);
        chk("async_rst_empty", {31'b0, empty}, 32'd1);
        chk("async_rst_ready", {31'b0, st_ready}, 32'd1);
        tick(); ld_valid = 1'b0;
        tick(); rst_n = 1'b1;
        repeat (5) tick();
        chk("post_rst_empty", {31'b0, empty}, 32'd1);

        for (int i = 0; i < 20 && (exp_q.size() != 0 || aerr_q.size() != 0); i++) tick();
        chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
        chk("aerr_outstanding", 32'(aerr_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
